// File: rtl/cpu_pkg.sv
// Shared datapath constants: operating modes of the selector and a clog2 helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package cpu_pkg;

    localparam int MODE_SEL = 0;  // explicit select input picks the source
    localparam int MODE_RR  = 1;  // round-robin among valid sources

    // Ceiling log2, usable in constant expressions for port widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr, wrapping.
// Latency: grant is combinational from req; rr_ptr moves one edge after an accepted grant.
// Backpressure: rr_ptr only advances when the caller signals an accepted transfer.
//
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   req            per-channel request (the channel valids)
//   advance        the current grant was taken this cycle
//   grant          one-hot grant, all zero when nobody requests
//   grant_idx      binary index of the granted channel (0 when nobody requests)
module rr_arbiter
    import cpu_pkg::*;
#(
    parameter  int N_IN  = 4,
    localparam int SEL_W = (clog2(N_IN) < 1) ? 1 : clog2(N_IN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  req,
    input  logic             advance,
    output logic [N_IN-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [SEL_W-1:0]  rr_ptr;
    logic [2*N_IN-1:0] req_dbl;
    logic [N_IN-1:0]   req_rot;
    logic              found;
    int                idx;
    int                nxt;

    // Doubling the request vector and shifting by rr_ptr turns the wrapped scan
    // into a plain lowest-bit-first priority pick on req_rot.
    assign req_dbl = {req, req} >> rr_ptr;
    assign req_rot = req_dbl[N_IN-1:0];

    always_comb begin
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_IN; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                idx   = int'(rr_ptr) + k;
                if (idx >= N_IN) begin
                    idx = idx - N_IN;
                end
            end
        end
        nxt = idx + 1;
        if (nxt >= N_IN) begin
            nxt = 0;
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < N_IN; i++) begin
            grant[i] = found && (i == idx);
        end
    end

    assign grant_idx = SEL_W'(idx);

    // The pointer moves to the channel after the one just served, so a
    // continuously valid channel cannot starve its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (advance && found) begin
            rr_ptr <= SEL_W'(nxt);
        end
    end

endmodule

// File: rtl/mux_arb_nx1.sv
// N-input WIDTH-bit selector (explicit select or round-robin) with a registered output.
// Latency: one cycle from input transfer to out_valid.
// Backpressure: in_ready is combinational from out_ready; no skid, a stall drops all in_ready.
//
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   in_data        channel i at bits [i*WIDTH +: WIDTH]
//   in_valid       per-channel valid
//   in_ready       per-channel ready, at most one bit high
//   sel            channel select (explicit-select mode only)
//   out_data       registered selected data
//   out_valid      out_data holds an untaken item
//   out_ready      consumer accepts out_data
//   out_src        channel index that supplied out_data
module mux_arb_nx1
    import cpu_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_IN  = 4,
    parameter  int MODE  = MODE_SEL,
    localparam int SEL_W = (clog2(N_IN) < 1) ? 1 : clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_src
);

    logic             can_load;
    logic             xfer;
    logic [N_IN-1:0]  grant;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] mux_data;

    assign can_load = !out_valid || out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic unused_sel;
            assign unused_sel = ^sel;

            rr_arbiter #(
                .N_IN (N_IN)
            ) u_arb (
                .clk       (clk),
                .reset     (reset),
                .req       (in_valid),
                .advance   (xfer),
                .grant     (grant),
                .grant_idx (grant_idx)
            );
        end else begin : g_sel
            // Out-of-range sel matches no channel, so nothing is granted.
            always_comb begin
                grant = '0;
                for (int i = 0; i < N_IN; i++) begin
                    grant[i] = (int'(sel) == i);
                end
            end
            assign grant_idx = sel;
        end
    endgenerate

    assign in_ready = (can_load && !reset) ? grant : '0;
    assign xfer     = |(in_valid & in_ready);

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant[i]) begin
                mux_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A new transfer overwrites the register (also when the old item is consumed
    // at the same edge); a bare consume only clears valid and keeps data/src.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_src   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed bench for mux_arb_nx1: select mode (N=4), round-robin mode (N=4), select mode (N=3).
// Latency: checks sample 2 time units after each rising edge.
// Backpressure: stalls driven explicitly through out_ready.
module tb_mux_arb_nx1;

    logic clk;
    logic reset;

    // select-mode, 4 channels
    logic [31:0] s_data;
    logic [3:0]  s_valid, s_ready;
    logic [1:0]  s_sel, s_src;
    logic [7:0]  s_odata;
    logic        s_ovalid, s_oready;

    // round-robin mode, 4 channels
    logic [31:0] r_data;
    logic [3:0]  r_valid, r_ready;
    logic [1:0]  r_sel, r_src;
    logic [7:0]  r_odata;
    logic        r_ovalid, r_oready;

    // select-mode, 3 channels
    logic [23:0] t_data;
    logic [2:0]  t_valid, t_ready;
    logic [1:0]  t_sel, t_src;
    logic [7:0]  t_odata;
    logic        t_ovalid, t_oready;

    int n_cmp;
    int n_err;

    mux_arb_nx1 #(.WIDTH(8), .N_IN(4), .MODE(0)) u_sel (
        .clk(clk), .reset(reset), .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
        .sel(s_sel), .out_data(s_odata), .out_valid(s_ovalid), .out_ready(s_oready),
        .out_src(s_src)
    );

    mux_arb_nx1 #(.WIDTH(8), .N_IN(4), .MODE(1)) u_rr (
        .clk(clk), .reset(reset), .in_data(r_data), .in_valid(r_valid), .in_ready(r_ready),
        .sel(r_sel), .out_data(r_odata), .out_valid(r_ovalid), .out_ready(r_oready),
        .out_src(r_src)
    );

    mux_arb_nx1 #(.WIDTH(8), .N_IN(3), .MODE(0)) u_sel3 (
        .clk(clk), .reset(reset), .in_data(t_data), .in_valid(t_valid), .in_ready(t_ready),
        .sel(t_sel), .out_data(t_odata), .out_valid(t_ovalid), .out_ready(t_oready),
        .out_src(t_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [1:0] exp_src [7];

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

        reset    = 1'b1;
        s_data   = '0; s_valid = '0; s_sel = '0; s_oready = 1'b0;
        r_data   = {8'd3, 8'd2, 8'd1, 8'd0}; r_valid = '0; r_sel = '0; r_oready = 1'b0;
        t_data   = {8'h0C, 8'h0B, 8'h0A}; t_valid = '0; t_sel = '0; t_oready = 1'b0;

        // reset state; ready held low during reset even with a selected valid source
        s_valid = 4'b0001;
        s_data[7:0] = 8'hA5;
        #3;
        chk("rst_valid", 32'(s_ovalid), 32'd0);
        chk("rst_data",  32'(s_odata),  32'd0);
        chk("rst_src",   32'(s_src),    32'd0);
        chk("rst_ready", 32'(s_ready),  32'd0);
        chk("rst_rr_ready", 32'(r_ready), 32'd0);

        // 1. reset mid-stall
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t1_ready", 32'(s_ready), 32'b0001);
        step();
        chk("t1_load_valid", 32'(s_ovalid), 32'd1);
        chk("t1_load_data",  32'(s_odata),  32'hA5);
        s_valid = '0;
        #1;
        chk("t1_stall_ready", 32'(s_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("t1_async_valid", 32'(s_ovalid), 32'd0);
        chk("t1_async_data",  32'(s_odata),  32'd0);
        reset = 1'b0;

        // 2. select-mode streaming on channel 2
        s_sel = 2'd2; s_valid = 4'b0100; s_data[23:16] = 8'h10; s_oready = 1'b1;
        #1;
        chk("t2_ready", 32'(s_ready), 32'b0100);
        step();
        chk("t2_d0", 32'(s_odata), 32'h10);
        chk("t2_s0", 32'(s_src), 32'd2);
        chk("t2_v0", 32'(s_ovalid), 32'd1);
        s_data[23:16] = 8'h11;
        step();
        chk("t2_d1", 32'(s_odata), 32'h11);
        s_data[23:16] = 8'h12;
        step();
        chk("t2_d2", 32'(s_odata), 32'h12);
        chk("t2_v2", 32'(s_ovalid), 32'd1);
        s_valid = '0;
        step();
        chk("t2_drain_valid", 32'(s_ovalid), 32'd0);
        chk("t2_drain_data",  32'(s_odata),  32'h12);
        chk("t2_drain_src",   32'(s_src),    32'd2);

        // 3. select-mode stall with sel change
        s_sel = 2'd1; s_valid = 4'b1010;
        s_data[15:8] = 8'h3C; s_data[31:24] = 8'hC3;
        step();
        chk("t3_load_data", 32'(s_odata), 32'h3C);
        chk("t3_load_src",  32'(s_src),   32'd1);
        s_oready = 1'b0;
        s_sel = 2'd3;
        #1;
        chk("t3_stall_ready", 32'(s_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_data",  32'(s_odata),  32'h3C);
            chk("t3_hold_src",   32'(s_src),    32'd1);
            chk("t3_hold_valid", 32'(s_ovalid), 32'd1);
            chk("t3_hold_ready", 32'(s_ready),  32'd0);
        end
        s_oready = 1'b1;
        #1;
        chk("t3_release_ready", 32'(s_ready), 32'b1000);
        step();
        chk("t3_next_data",  32'(s_odata),  32'hC3);
        chk("t3_next_src",   32'(s_src),    32'd3);
        chk("t3_next_valid", 32'(s_ovalid), 32'd1);
        s_valid = '0;
        step();
        chk("t3_drain_valid", 32'(s_ovalid), 32'd0);

        // 4. round-robin fairness, all channels valid
        r_valid = 4'b1111; r_oready = 1'b1;
        #1;
        chk("t4_ready0", 32'(r_ready), 32'b0001);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t4_src",   32'(r_src),    32'(exp_src[i]));
            chk("t4_data",  32'(r_odata),  32'(exp_src[i]));
            chk("t4_valid", 32'(r_ovalid), 32'd1);
        end

        // 5. skip and wrap: pointer is now 3
        r_valid = 4'b0101;
        #1;
        chk("t5_ready_wrap", 32'(r_ready), 32'b0001);
        step();
        chk("t5_src0", 32'(r_src), 32'd0);
        chk("t5_data0", 32'(r_odata), 32'd0);
        #1;
        chk("t5_ready_skip", 32'(r_ready), 32'b0100);
        step();
        chk("t5_src2", 32'(r_src), 32'd2);
        r_valid = 4'b1100;
        #1;
        chk("t5_ptr3_ready", 32'(r_ready), 32'b1000);
        r_valid = '0;
        #1;
        chk("t5_idle_ready", 32'(r_ready), 32'd0);
        step();
        chk("t5_drain_valid", 32'(r_ovalid), 32'd0);
        chk("t5_drain_src",   32'(r_src),    32'd2);

        // 6. out-of-range select with 3 channels
        t_sel = 2'd3; t_valid = 3'b111; t_oready = 1'b1;
        #1;
        chk("t6_ready", 32'(t_ready), 32'd0);
        step();
        chk("t6_valid", 32'(t_ovalid), 32'd0);
        t_sel = 2'd1;
        #1;
        chk("t6_ready_sel1", 32'(t_ready), 32'b010);
        step();
        chk("t6_data", 32'(t_odata), 32'h0B);
        chk("t6_src",  32'(t_src),   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
